// File: rtl/spi_slave_pkg.sv
// Shared SPI mode decode and defaults for the SPI master/slave pair.
package spi_slave_pkg;

  // Word shifted out when nothing is pending (SD bus idle pattern).
  localparam logic [7:0] SPI_TX_IDLE_DEFAULT = 8'hFF;

  // Data is sampled on the rising SPI clock edge when CPOL == CPHA,
  // otherwise on the falling edge; shifting uses the opposite edge.
  function automatic logic spi_sample_on_rise(input logic cpol, input logic cpha);
    return (cpol == cpha);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser followed by an edge register; emits one-cycle
// rise/fall pulses in the clk domain for an asynchronous input.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  // sync_q[1:0] is the synchroniser, sync_q[2] the previous synced value.
  logic [2:0] sync_q;

  // Shift the pin value through the synchroniser and edge register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {3{RST_VAL}};
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_slave.sv
// SPI responder oversampling spi_clk/spi_cs/spi_mosi in the clk domain.
// Receives MSB-first words from MOSI and returns a buffered TX word on MISO.
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter logic                  CPOL       = 1'b1,
  parameter logic                  CPHA       = 1'b1,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE    = DATA_WIDTH'(SPI_TX_IDLE_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_clk,
  input  logic                  spi_cs,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int unsigned     CW          = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0]   LAST        = CW'(DATA_WIDTH - 1);
  localparam logic            SAMPLE_RISE = spi_sample_on_rise(CPOL, CPHA);

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [1:0] mosi_sync_q;
  logic       mosi_s;
  logic       sample_edge, shift_edge;

  // The SPI clock synchroniser resets to the idle level so no edge is seen
  // at reset release. CS resets low so a CS already low at release is not
  // mistaken for a fresh falling edge.
  spi_sync_edge #(.RST_VAL(CPOL)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_clk),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  spi_sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (spi_cs),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // MOSI only needs the two-flop synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
    end
  end

  assign mosi_s      = mosi_sync_q[1];
  assign sample_edge = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_edge  = SAMPLE_RISE ? sclk_fall : sclk_rise;

  logic                  active_q, active_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-2:0] rx_sh_q, rx_sh_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic [DATA_WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic                  fresh_q, fresh_d;
  logic                  miso_q, miso_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] next_word;
  logic [DATA_WIDTH-1:0] rx_word;
  logic                  load;

  // Frame control, RX deserialiser, TX serialiser and holding register.
  // fresh_q marks a just-loaded shifter whose MSB is presented on the next
  // shift edge instead of shifting; this covers both the CPHA=1 first edge
  // and the CPHA=0 word boundary with one mechanism.
  always_comb begin
    active_d    = active_q;
    cnt_d       = cnt_q;
    rx_sh_d     = rx_sh_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    tx_sh_d     = tx_sh_q;
    fresh_d     = fresh_q;
    miso_d      = miso_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    next_word   = hold_full_q ? hold_q : TX_IDLE;
    rx_word     = {rx_sh_q, mosi_s};

    if (cs_fall) begin
      active_d = 1'b1;
      cnt_d    = '0;
      load     = 1'b1;
      miso_d   = next_word[DATA_WIDTH-1];
      fresh_d  = CPHA;
    end else if (cs_rise) begin
      active_d = 1'b0;
      if (active_q && (cnt_q != '0)) begin
        frame_err_d = 1'b1;
      end
      cnt_d = '0;
    end else if (active_q) begin
      if (sample_edge) begin
        rx_sh_d = rx_word[DATA_WIDTH-2:0];
        if (cnt_q == LAST) begin
          cnt_d      = '0;
          rx_data_d  = rx_word;
          rx_valid_d = 1'b1;
          load       = 1'b1;
          fresh_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else if (shift_edge) begin
        if (fresh_q) begin
          miso_d  = tx_sh_q[DATA_WIDTH-1];
          fresh_d = 1'b0;
        end else begin
          tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b1};
          miso_d  = tx_sh_q[DATA_WIDTH-2];
        end
      end
    end

    if (load) begin
      tx_sh_d     = next_word;
      hold_full_d = 1'b0;
    end
    // A write coinciding with a load refills the just-emptied holding register.
    if (tx_valid && (!hold_full_q || load)) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q    <= 1'b0;
      cnt_q       <= '0;
      rx_sh_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      tx_sh_q     <= '0;
      fresh_q     <= 1'b0;
      miso_q      <= 1'b1;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      active_q    <= active_d;
      cnt_q       <= cnt_d;
      rx_sh_q     <= rx_sh_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      tx_sh_q     <= tx_sh_d;
      fresh_q     <= fresh_d;
      miso_q      <= miso_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = active_q;
  assign busy        = active_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_err   = frame_err_q;

endmodule
